// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
//
// Pixel-colour stage that sits directly behind the 640x480@60Hz timing
// generator on the 25 MHz pixel clock. It tracks the pixel column and line
// from the generator's DE/VSYNC stream and renders one of four 1-bit-per-
// channel test patterns. A debounced board key advances the pattern, and the
// change is held back until the next frame boundary (VSYNC falling edge) so
// that a frame is never torn between two patterns. HSYNC/VSYNC are delayed
// by one register so that they stay aligned with the registered RGB.
//
// Ports
//   clk       in   pixel clock (25 MHz)
//   reset     in   synchronous, active-high reset
//   in_hsync  in   HSYNC from timing generator, active-low
//   in_vsync  in   VSYNC from timing generator, active-low
//   in_de     in   active-video qualifier from timing generator
//   key_n     in   asynchronous pattern-select key, active-low
//   hys       out  HSYNC delayed 1 cycle
//   vys       out  VSYNC delayed 1 cycle
//   rgb_r/g/b out  colour, forced to 0 outside active video
//   mode      out  current pattern index (0..3)
// ---------------------------------------------------------------------------
module vga_pattern_gen #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int BAR_WIDTH       = 80,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic       in_de,
  input  logic       key_n,
  output logic       hys,
  output logic       vys,
  output logic       rgb_r,
  output logic       rgb_g,
  output logic       rgb_b,
  output logic [1:0] mode
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

  // Key path state
  logic             r_key_s1;
  logic             r_key_s2;
  logic             r_key_deb;
  logic [CNT_W-1:0] r_deb_cnt;
  logic             r_pending;
  logic [1:0]       r_mode;

  // Position tracking state
  logic [9:0] r_x;
  logic [8:0] r_y;
  logic       r_de_prev;

  // Output stage registers
  logic       r_hsync_p1;
  logic       r_vsync_p1;
  logic [2:0] r_rgb_p1;

  logic       w_vfall;
  logic       w_defall;
  logic       w_key_diff;
  logic       w_deb_done;
  logic       w_press;
  logic [2:0] w_pix;

  // Colour for the given position in the given pattern, as {r,g,b}.
  function automatic logic [2:0] pattern(input logic [1:0] m,
                                         input logic [9:0] x,
                                         input logic [8:0] y);
    int         q;
    logic [2:0] idx;
    logic [2:0] c;
    q   = int'(x) / BAR_WIDTH;
    idx = (q > 7) ? 3'd7 : 3'(q);
    case (m)
      2'd0:    c = ~idx;
      2'd1:    c = {3{~(x[5] ^ y[5])}};
      2'd2:    c = (x == 10'd0 || x == X_LAST || y == 9'd0 || y == Y_LAST)
                   ? 3'b111 : 3'b100;
      default: c = y[8:6];
    endcase
    return c;
  endfunction

  // r_vsync_p1 doubles as the previous-VSYNC history for edge detection;
  // both reset to 1 so no false edge is seen right after reset.
  assign w_vfall    = r_vsync_p1 & ~in_vsync;
  assign w_defall   = r_de_prev & ~in_de;
  assign w_key_diff = (r_key_s2 != r_key_deb);
  assign w_deb_done = w_key_diff && (r_deb_cnt == CNT_MAX);
  // Debounced value is about to fall 1->0: a press. Releases are ignored.
  assign w_press    = w_deb_done & ~r_key_s2;
  assign w_pix      = pattern(r_mode, r_x, r_y);

  // ---- key synchroniser, debounce and frame-boundary mode update ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_s1  <= 1'b1;
      r_key_s2  <= 1'b1;
      r_key_deb <= 1'b1;
      r_deb_cnt <= '0;
      r_pending <= 1'b0;
      r_mode    <= 2'd0;
    end else begin
      r_key_s1 <= key_n;
      r_key_s2 <= r_key_s1;
      if (w_deb_done) begin
        r_key_deb <= r_key_s2;
        r_deb_cnt <= '0;
      end else if (w_key_diff) begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end else begin
        r_deb_cnt <= '0;
      end
      // A press coinciding with the boundary re-arms pending, so it is
      // applied one frame later rather than lost.
      r_pending <= w_press | (r_pending & ~w_vfall);
      if (w_vfall && r_pending) begin
        r_mode <= r_mode + 2'd1;
      end
    end
  end

  // ---- pixel column / line counters ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x       <= '0;
      r_y       <= '0;
      r_de_prev <= 1'b0;
    end else begin
      r_de_prev <= in_de;
      if (!in_de) begin
        r_x <= '0;
      end else if (r_x != 10'h3FF) begin
        r_x <= r_x + 10'd1;
      end
      if (w_vfall) begin
        r_y <= '0;
      end else if (w_defall && r_y != 9'h1FF) begin
        r_y <= r_y + 9'd1;
      end
    end
  end

  // ---- output stage p1: colour and sync aligned ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync_p1 <= 1'b1;
      r_vsync_p1 <= 1'b1;
      r_rgb_p1   <= 3'b000;
    end else begin
      r_hsync_p1 <= in_hsync;
      r_vsync_p1 <= in_vsync;
      r_rgb_p1   <= in_de ? w_pix : 3'b000;
    end
  end

  assign hys   = r_hsync_p1;
  assign vys   = r_vsync_p1;
  assign rgb_r = r_rgb_p1[2];
  assign rgb_g = r_rgb_p1[1];
  assign rgb_b = r_rgb_p1[0];
  assign mode  = r_mode;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_pattern_gen
//
// Directed bench. The driver sets inputs on the falling clock edge and, for
// each cycle, queues the outputs the DUT must show after the next rising
// edge: sync equal to the driven sync, mode as stated by the stimulus
// sequence, rgb=000 in blanking, and hand-computed rgb at chosen pixels.
// A monitor samples 1 time unit after each rising edge and compares.
// ---------------------------------------------------------------------------
module tb_vga_pattern_gen;

  localparam int DEB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_hsync = 1'b1;
  logic       in_vsync = 1'b1;
  logic       in_de = 1'b0;
  logic       key_n = 1'b1;
  logic       hys, vys, rgb_r, rgb_g, rgb_b;
  logic [1:0] mode;

  vga_pattern_gen #(
    .H_ACTIVE(640), .V_ACTIVE(480), .BAR_WIDTH(80), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .in_de(in_de), .key_n(key_n), .hys(hys), .vys(vys),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b), .mode(mode)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic       hs;
    logic       vs;
    logic       chk;
    logic [2:0] rgb;
    logic [1:0] md;
    int         tag;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [1:0] m_exp = 2'd0;
  int         b_start = -1000;
  int         pq[$];
  int         pl[$];
  int         cx[$];
  logic [2:0] cv[$];

  // Key level for a given cycle: bounce window, then scheduled presses.
  function automatic logic key_at(input int c);
    if (c >= b_start && c < b_start + 60)
      return (((c - b_start) / 5) % 2 == 0) ? 1'b0 : 1'b1;
    foreach (pq[i])
      if (c >= pq[i] && c < pq[i] + pl[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string nm, input logic [3:0] got,
                       input logic [3:0] want, input int t);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s (inputs of cycle %0d): got %0h expected %0h",
               nm, t, got, want);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("hys", {3'b0, hys}, {3'b0, e.hs}, e.tag);
        check("vys", {3'b0, vys}, {3'b0, e.vs}, e.tag);
        check("mode", {2'b0, mode}, {2'b0, e.md}, e.tag);
        if (e.chk)
          check("rgb", {1'b0, rgb_r, rgb_g, rgb_b}, {1'b0, e.rgb}, e.tag);
      end
    end
  end

  task automatic drive(input logic rst_i, input logic hs, input logic vs,
                       input logic de, input logic crgb,
                       input logic [2:0] ergb);
    exp_t e;
    @(negedge clk);
    reset    = rst_i;
    in_hsync = hs;
    in_vsync = vs;
    in_de    = de;
    key_n    = key_at(cyc);
    if (rst_i) begin
      e.hs = 1'b1; e.vs = 1'b1; e.chk = 1'b1; e.rgb = 3'b000; e.md = 2'd0;
    end else begin
      e.hs  = hs;
      e.vs  = vs;
      e.chk = crgb | ~de;
      e.rgb = de ? ergb : 3'b000;
      e.md  = m_exp;
    end
    e.tag = cyc;
    sb.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic blank();
    idle(2);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    idle(2);
  endtask

  task automatic add_chk(input int x, input logic [2:0] v);
    cx.push_back(x);
    cv.push_back(v);
  endtask

  // One active line of len pixels followed by horizontal blanking.
  task automatic line(input int len);
    logic       c;
    logic [2:0] v;
    for (int k = 0; k < len; k++) begin
      c = 1'b0;
      v = 3'b000;
      foreach (cx[i]) if (cx[i] == k) begin c = 1'b1; v = cv[i]; end
      drive(1'b0, 1'b1, 1'b1, 1'b1, c, v);
    end
    cx.delete();
    cv.delete();
    blank();
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) line(2);
  endtask

  // Frame boundary; mode m_after is required from the VSYNC-fall cycle on.
  task automatic vsync(input logic [1:0] m_after);
    idle(2);
    m_exp = m_after;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    idle(2);
  endtask

  task automatic press(input int at, input int len);
    pq.push_back(at);
    pl.push_back(len);
  endtask

  initial begin
    // Power-on reset
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    idle(5);

    // Colour bars over a full line
    vsync(2'd0);
    add_chk(0, 3'b111);   add_chk(79, 3'b111);  add_chk(80, 3'b110);
    add_chk(160, 3'b101); add_chk(240, 3'b100); add_chk(320, 3'b011);
    add_chk(400, 3'b010); add_chk(480, 3'b001); add_chk(560, 3'b000);
    add_chk(639, 3'b000);
    line(640);

    // Bouncing key: never stable long enough, no mode change
    b_start = cyc;
    idle(80);
    vsync(2'd0);
    add_chk(0, 3'b111);
    line(10);

    // Clean press held 40 cycles: mode waits for the boundary
    press(cyc, 40);
    idle(70);
    vsync(2'd1);
    add_chk(0, 3'b111); add_chk(31, 3'b111); add_chk(32, 3'b000);
    line(64);
    lines(31);
    add_chk(0, 3'b000); add_chk(32, 3'b111);
    line(40);

    // Three presses in one frame give a single increment
    press(cyc + 2, 25); press(cyc + 62, 25); press(cyc + 122, 25);
    idle(200);
    vsync(2'd2);
    idle(10);
    vsync(2'd2);

    // Press event lands on the VSYNC-fall cycle: key falls DEB+1 cycles
    // before that cycle (2 synchroniser stages + DEB-1 counts).
    press(cyc + 20 - (DEB + 1), 25);
    idle(18);
    vsync(2'd2);
    idle(30);
    vsync(2'd3);

    // One press per boundary
    press(cyc + 2, 25); idle(60); vsync(2'd0);
    press(cyc + 2, 25); idle(60); vsync(2'd1);
    press(cyc + 2, 25); idle(60); vsync(2'd2);

    // Mode 2 full frame (press during it for the next boundary)
    press(cyc + 700, 25);
    add_chk(0, 3'b111); add_chk(320, 3'b111); add_chk(639, 3'b111);
    line(640);
    lines(239);
    add_chk(0, 3'b111); add_chk(1, 3'b100); add_chk(320, 3'b100);
    add_chk(638, 3'b100); add_chk(639, 3'b111);
    line(640);
    lines(237);
    add_chk(1, 3'b100);
    line(2);
    add_chk(0, 3'b111); add_chk(1, 3'b111);
    line(2);
    vsync(2'd3);

    // Mode 3 full frame
    press(cyc + 5, 25);
    lines(63);
    add_chk(0, 3'b000); add_chk(1, 3'b000);
    line(2);
    add_chk(0, 3'b001); add_chk(1, 3'b001);
    line(2);
    lines(135);
    add_chk(0, 3'b011);
    line(2);
    lines(278);
    add_chk(0, 3'b111);
    line(2);
    vsync(2'd0);

    press(cyc + 2, 25); idle(60); vsync(2'd1);

    // Pending press, then reset mid-line: everything returns to reset state
    press(cyc + 2, 25);
    idle(60);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
    m_exp = 2'd0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b111);
    blank();
    vsync(2'd0);
    add_chk(0, 3'b111); add_chk(79, 3'b111); add_chk(80, 3'b110);
    line(100);
    idle(3);

    // Let the monitor consume the remaining expectations
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
